gamma_decoder: RTL and testbench

GAMMA_DECODER -- requirements
Module: gamma_decoder

---
 rtl/gamma_decoder.sv | 72 +++++++
 tb/tb_gamma_decoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gamma_decoder.sv
// gamma_decoder: subtracts an LFSR gamma byte from each 9-bit encoded word to recover plaintext, flagging out-of-range results
module gamma_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [15:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [7:0]       err_cnt,
  output logic             seeded
);
  localparam logic [0:0] UNSEEDED = 1'b0;
  localparam logic [0:0] RUN      = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [15:0]      s_q, s_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [9:0]       diff;
  logic             err;
  logic             xfer;
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready) && !seed_load;
  assign xfer      = in_valid && in_ready;
  assign diff      = {1'b0, in_data} - {2'b00, s_q[7:0]};
  // bit 9 marks a negative result, bit 8 (when non-negative) marks a result above 255
  assign err       = diff[9] | diff[8];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign byte_cnt  = byte_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign seeded    = (state_q == RUN);
  always_comb begin
    state_d     = seed_load ? RUN : state_q;
    s_d         = seed_load ? ((seed == 16'h0000) ? 16'hACE1 : seed)
                : xfer ? {s_q[14:0], s_q[15] ^ s_q[13] ^ s_q[12] ^ s_q[10]} : s_q;
    out_valid_d = seed_load ? 1'b0 : xfer ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_data_d  = xfer ? diff[7:0] : out_data_q;
    out_err_d   = xfer ? err : out_err_q;
    byte_cnt_d  = xfer ? byte_cnt_q + CNT_W'(1) : byte_cnt_q;
    err_cnt_d   = (xfer && err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNSEEDED;
      s_q         <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_err_q   <= 1'b0;
      byte_cnt_q  <= '0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      byte_cnt_q  <= byte_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_gamma_decoder.sv
// tb_gamma_decoder: randomized scoreboard bench for gamma_decoder against an arithmetic reference model
module tb_gamma_decoder;
  localparam int CW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_load = 1'b0;
  logic [15:0]   seed = 16'h0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [8:0]    in_data = 9'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_err;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    err_cnt;
  logic          seeded;
  gamma_decoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .byte_cnt(byte_cnt), .err_cnt(err_cnt), .seeded(seeded)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic [7:0] bc;
    logic [7:0] ec;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] m_lfsr = 16'h0;
  int  m_bc = 0;
  int  m_ec = 0;
  logic mv_cur = 1'b0, mv_nxt = 1'b0;
  logic sd_cur = 1'b0, sd_nxt = 1'b0;
  logic flush = 1'b0;
  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  task automatic step(input logic sl, input logic [15:0] sd, input logic iv, input logic [8:0] id, input logic ordy);
    int d;
    logic e;
    logic mrdy;
    @(posedge clk);
    mv_cur = mv_nxt;
    sd_cur = sd_nxt;
    if (flush) begin q.delete(); flush = 1'b0; end
    #1;
    seed_load = sl; seed = sd; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    mrdy = sd_cur && (!mv_cur || ordy) && !sl;
    chk("in_ready", int'(in_ready), int'(mrdy));
    if (sl) begin
      m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
      sd_nxt = 1'b1;
      mv_nxt = 1'b0;
      flush = 1'b1;
    end else if (iv && mrdy) begin
      d = int'(id) - int'(m_lfsr[7:0]);
      e = (d < 0) || (d > 255);
      m_bc = (m_bc + 1) % (1 << CW);
      m_ec = (e && m_ec < 255) ? m_ec + 1 : m_ec;
      q.push_back('{data: 8'(d & 255), err: e, bc: 8'(m_bc), ec: 8'(m_ec)});
      m_lfsr = lfsr_next(m_lfsr);
      mv_nxt = 1'b1;
    end else if (ordy) begin
      mv_nxt = 1'b0;
    end else begin
      mv_nxt = mv_cur;
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", int'(out_valid), int'(mv_cur));
      chk("seeded", int'(seeded), int'(sd_cur));
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got data %0h with no expected entry", out_data);
        end else begin
          chk("out_data", int'(out_data), int'(q[0].data));
          chk("out_err", int'(out_err), int'(q[0].err));
          chk("byte_cnt", int'(byte_cnt), int'(q[0].bc));
          chk("err_cnt", int'(err_cnt), int'(q[0].ec));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step(0, 16'h0, 1, 9'h155, 1);
    step(0, 16'h0, 1, 9'h0AA, 1);
    step(1, 16'h00FF, 0, 9'h0, 1);
    step(0, 16'h0, 1, 9'h1FE, 1);
    step(0, 16'h0, 0, 9'h0, 1);
    chk("lfsr_after_step", int'(dut.s_q), 16'h01FE);
    step(1, 16'h00FF, 0, 9'h0, 1);
    step(0, 16'h0, 1, 9'h010, 1);
    step(0, 16'h0, 0, 9'h0, 1);
    step(1, 16'h00FF, 0, 9'h0, 1);
    step(0, 16'h0, 1, 9'h1FE, 0);
    repeat (3) step(0, 16'h0, 1, 9'h1FD, 0);
    step(0, 16'h0, 1, 9'h1FD, 1);
    step(0, 16'h0, 0, 9'h0, 1);
    step(1, 16'h0000, 0, 9'h0, 1);
    step(0, 16'h0, 0, 9'h0, 1);
    chk("lfsr_zero_seed", int'(dut.s_q), 16'hACE1);
    step(0, 16'h0, 1, 9'h0E1, 1);
    step(0, 16'h0, 1, 9'h033, 0);
    step(0, 16'h0, 0, 9'h0, 0);
    step(1, 16'h1234, 1, 9'h044, 0);
    step(0, 16'h0, 0, 9'h0, 0);
    chk("byte_cnt_kept", int'(byte_cnt), m_bc);
    chk("err_cnt_kept", int'(err_cnt), m_ec);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rs;
      rs = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step($urandom_range(0, 39) == 0, rs, $urandom_range(0, 3) != 0,
           9'($urandom), $urandom_range(0, 3) != 0);
    end
    step(1, 16'h5A5A, 0, 9'h0, 1);
    for (int i = 0; i < 300; i++) step(0, 16'h0, 1, 9'h1FF, 1);
    step(0, 16'h0, 0, 9'h0, 1);
    chk("err_cnt_sat", int'(err_cnt), 255);
    step(0, 16'h0, 1, 9'h1FF, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_byte_cnt", int'(byte_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_seeded", int'(seeded), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_lfsr", int'(dut.s_q), 0);
    q.delete();
    mv_cur = 1'b0; mv_nxt = 1'b0; sd_cur = 1'b0; sd_nxt = 1'b0; flush = 1'b0;
    m_bc = 0; m_ec = 0; m_lfsr = 16'h0;
    seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    step(0, 16'h0, 1, 9'h1AB, 1);
    step(0, 16'h0, 1, 9'h0CD, 1);
    step(1, 16'hBEEF, 0, 9'h0, 1);
    for (int i = 0; i < 20; i++) step(0, 16'h0, 1, 9'($urandom), $urandom_range(0, 1) == 1);
    repeat (3) step(0, 16'h0, 0, 9'h0, 1);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_byte_cnt", int'(byte_cnt), m_bc);
    chk("final_err_cnt", int'(err_cnt), m_ec);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
